hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall/flush controller that consumes the `hazard_detected` verdict from the hazard detection unit, plus branch and memory-wait status, and drives the freeze, flush and bubble controls of the PC and pipeline registers. It sits beside the ID stage. It converts per-cycle hazard and branch information into registered multi-cycle flush sequences and memory-wait freezes, with a watchdog that traps a stuck memory handshake.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: IF_ID flush cycles per taken branch. Legal range 1..3.
- `WAIT_LIMIT`, default 255: maximum consecutive memory-wait cycles before fault. Legal range 1..65535.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `hazard_detected`  in  1  RAW hazard verdict for the instruction in ID.
- `branch_taken`  in  1  branch/jump in ID resolved as taken.
- `mem_req`  in  1  MEM stage is issuing a read or write.
- `mem_ready`  in  1  memory completes the access this cycle.
- `pc_freeze`  out  1  hold PC.
- `if_id_freeze`  out  1  hold IF_ID register.
- `if_id_flush`  out  1  load a NOP into IF_ID.
- `id_exe_bubble`  out  1  load a NOP into ID_EXE.
- `back_freeze`  out  1  hold ID_EXE, EXE_MEM and MEM_WB.
- `mem_timeout`  out  1  sticky watchdog fault.
- `stall_count`  out  32  hazard-stall cycles (statistics).
- `flush_count`  out  32  flush cycles (statistics).

## Operation
- States: RUN, FLUSH, WAIT, FAULT. Registered `flush_left` (2 bit), `wait_cnt` (16 bit) and `ret_state` (RUN or FLUSH).
- `wait_now = mem_req && !mem_ready`.
- `wait_now` in RUN or FLUSH:
  - Assert all five controls: `pc_freeze`, `if_id_freeze`, `back_freeze` at 1; `if_id_flush` and `id_exe_bubble` at 0.
  - Next state WAIT. `ret_state` = current state. `wait_cnt` = 1. `flush_left` holds.
  - The branch and hazard inputs are ignored that cycle.
- WAIT:
  - While `wait_now` is true: all freezes stay 1 and `wait_cnt` increments.
  - If `wait_cnt == WAIT_LIMIT` and `wait_now` is still true: go to FAULT.
  - When `mem_ready` rises: freezes drop that same cycle. The cycle is evaluated with the `ret_state` rules below, and the state updates from those rules.
- RUN, not waiting, priority is hazard over branch:
  - `hazard_detected`: `pc_freeze`, `if_id_freeze` and `id_exe_bubble` are 1. `branch_taken` is ignored, because its operands are unresolved.
  - Else `branch_taken`: `if_id_flush` is 1. If `FLUSH_CYCLES > 1`, go to FLUSH with `flush_left = FLUSH_CYCLES-1`.
  - Else all outputs are 0.
- FLUSH, not waiting: `if_id_flush` is 1 and `flush_left` decrements. Go to RUN when `flush_left` reaches 0. `hazard_detected` and `branch_taken` are ignored, because the ID content is a bubble.
- FAULT: `pc_freeze`, `if_id_freeze` and `back_freeze` are held at 1, and `mem_timeout` is 1. Only reset exits FAULT.
- `if_id_flush` and `if_id_freeze` are never both 1.

## Timing
- `mem_timeout` and the counters are registered. All other outputs are combinational from the registered state and the current inputs, so they act in the same cycle.
- Reset (`rst` = 0, asynchronous): state RUN, `flush_left` = 0, `wait_cnt` = 0, counters 0, `mem_timeout` 0.
- While `rst` = 0, all control outputs are forced to 0.
- Reset mid-FLUSH, mid-WAIT or in FAULT aborts the sequence. The first cycle after release is RUN.
- Branch flush latency: the flush is applied in the same cycle as `branch_taken`, and lasts `FLUSH_CYCLES` non-waiting cycles in total. Wait cycles in the middle do not consume flush cycles.
- Watchdog: FAULT is entered on the clock edge that ends the `WAIT_LIMIT`-th consecutive `wait_now` cycle. `mem_timeout` is visible on the next cycle.
- `mem_ready` arriving in the same cycle as the limit is reached: no fault.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_count` increments on each cycle with a hazard stall or any freeze from `wait_now`.
  - `flush_count` increments on each cycle with `if_id_flush` = 1.
  - Both counters saturate at 0xFFFFFFFF and become visible the cycle after the event.
- Not defined: both ports are present and tied to 0, with no counter registers.

## Test plan
- Hazard pulse: `hazard_detected` = 1 for 2 cycles in RUN -> `pc_freeze`, `if_id_freeze` and `id_exe_bubble` are 1 for exactly those 2 cycles. With stats enabled, `stall_count` = 2.
- Branch with `FLUSH_CYCLES=3`: 1-cycle `branch_taken` -> `if_id_flush` is 1 for 3 cycles, then RUN. A `branch_taken` in cycle 2 is ignored.
- Branch plus hazard in the same cycle -> stall only, `if_id_flush` = 0.
- Memory wait mid-flush: `FLUSH_CYCLES=2`, branch, then `wait_now` for 4 cycles -> all freezes are 1 for 4 cycles, then 1 more `if_id_flush` cycle.
- Watchdog: `WAIT_LIMIT=4`, `mem_ready` held at 0 -> `mem_timeout` = 1 after the 4th wait cycle and stays 1. Async reset asserted mid-cycle -> outputs are 0 immediately and `mem_timeout` clears.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller beside the ID stage: hazard stalls, multi-cycle branch flushes,
// memory-wait freezes and a stuck-handshake watchdog. Optional statistics via HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_LIMIT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_freeze,
    output logic        if_id_freeze,
    output logic        if_id_flush,
    output logic        id_exe_bubble,
    output logic        back_freeze,
    output logic        mem_timeout,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);
    typedef enum logic [1:0] {RUN, FLUSH, WAIT, FAULT} state_t;

    localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [16:0] LIMIT        = 17'(WAIT_LIMIT);

    state_t      state_reg, state_next;
    state_t      ret_state_reg, ret_state_next;
    state_t      eval_state;
    logic [1:0]  flush_left_reg, flush_left_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        mem_timeout_reg;

    logic        wait_now;
    logic        pc_frz, ifid_frz, ifid_fl, bubble, back_frz;

    assign wait_now = mem_req && !mem_ready;
    // A WAIT that releases this cycle behaves like the state it interrupted.
    assign eval_state = (state_reg == WAIT) ? ret_state_reg : state_reg;

    always_comb begin
        pc_frz          = 1'b0;
        ifid_frz        = 1'b0;
        ifid_fl         = 1'b0;
        bubble          = 1'b0;
        back_frz        = 1'b0;
        state_next      = state_reg;
        ret_state_next  = ret_state_reg;
        flush_left_next = flush_left_reg;
        wait_cnt_next   = wait_cnt_reg;

        if (state_reg == FAULT) begin
            pc_frz   = 1'b1;
            ifid_frz = 1'b1;
            back_frz = 1'b1;
        end else if (wait_now) begin
            pc_frz   = 1'b1;
            ifid_frz = 1'b1;
            back_frz = 1'b1;
            if (state_reg == WAIT) begin
                // wait_cnt counts earlier wait cycles; +1 includes the current one.
                if ({1'b0, wait_cnt_reg} + 17'd1 >= LIMIT)
                    state_next = FAULT;
                else
                    wait_cnt_next = wait_cnt_reg + 16'd1;
            end else begin
                ret_state_next = state_reg;
                wait_cnt_next  = 16'd1;
                state_next     = (LIMIT <= 17'd1) ? FAULT : WAIT;
            end
        end else begin
            wait_cnt_next = 16'd0;
            if (eval_state == FLUSH) begin
                ifid_fl         = 1'b1;
                flush_left_next = flush_left_reg - 2'd1;
                state_next      = (flush_left_reg <= 2'd1) ? RUN : FLUSH;
            end else begin
                state_next = RUN;
                if (hazard_detected) begin
                    pc_frz   = 1'b1;
                    ifid_frz = 1'b1;
                    bubble   = 1'b1;
                end else if (branch_taken) begin
                    ifid_fl = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next      = FLUSH;
                        flush_left_next = FLUSH_RELOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            ret_state_reg   <= RUN;
            flush_left_reg  <= 2'd0;
            wait_cnt_reg    <= 16'd0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ret_state_reg   <= ret_state_next;
            flush_left_reg  <= flush_left_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= (state_next == FAULT);
        end
    end

    assign pc_freeze     = rst & pc_frz;
    assign if_id_freeze  = rst & ifid_frz;
    assign if_id_flush   = rst & ifid_fl;
    assign id_exe_bubble = rst & bubble;
    assign back_freeze   = rst & back_frz;
    assign mem_timeout   = mem_timeout_reg;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_reg, flush_count_reg;
    logic        stall_event;

    // Fault freezes are not counted: they do not come from a live memory wait.
    assign stall_event = bubble || (wait_now && state_reg != FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_reg <= 32'd0;
            flush_count_reg <= 32'd0;
        end else begin
            if (stall_event && stall_count_reg != 32'hFFFF_FFFF)
                stall_count_reg <= stall_count_reg + 32'd1;
            if (ifid_fl && flush_count_reg != 32'hFFFF_FFFF)
                flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: four parameterisations share one stimulus stream and are
// checked every cycle against a priority-based reference model.
module tb_hazard_stall_ctrl;
    localparam int N = 4;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_freeze [N];
    logic        if_id_freeze [N];
    logic        if_id_flush [N];
    logic        id_exe_bubble [N];
    logic        back_freeze [N];
    logic        mem_timeout [N];
    logic [31:0] stall_count [N];
    logic [31:0] flush_count [N];

    int fc_p [N] = '{3, 2, 1, 1};
    int wl_p [N] = '{4, 6, 255, 1};

    int     m_fl [N];
    int     m_waits [N];
    bit     m_fault [N];
    longint m_sc [N];
    longint m_fc [N];

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.FLUSH_CYCLES(3), .WAIT_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze[0]),
        .if_id_freeze(if_id_freeze[0]), .if_id_flush(if_id_flush[0]),
        .id_exe_bubble(id_exe_bubble[0]), .back_freeze(back_freeze[0]),
        .mem_timeout(mem_timeout[0]), .stall_count(stall_count[0]), .flush_count(flush_count[0]));
    hazard_stall_ctrl #(.FLUSH_CYCLES(2), .WAIT_LIMIT(6)) dut_b (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze[1]),
        .if_id_freeze(if_id_freeze[1]), .if_id_flush(if_id_flush[1]),
        .id_exe_bubble(id_exe_bubble[1]), .back_freeze(back_freeze[1]),
        .mem_timeout(mem_timeout[1]), .stall_count(stall_count[1]), .flush_count(flush_count[1]));
    hazard_stall_ctrl dut_c (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze[2]),
        .if_id_freeze(if_id_freeze[2]), .if_id_flush(if_id_flush[2]),
        .id_exe_bubble(id_exe_bubble[2]), .back_freeze(back_freeze[2]),
        .mem_timeout(mem_timeout[2]), .stall_count(stall_count[2]), .flush_count(flush_count[2]));
    hazard_stall_ctrl #(.FLUSH_CYCLES(1), .WAIT_LIMIT(1)) dut_d (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze[3]),
        .if_id_freeze(if_id_freeze[3]), .if_id_flush(if_id_flush[3]),
        .id_exe_bubble(id_exe_bubble[3]), .back_freeze(back_freeze[3]),
        .mem_timeout(mem_timeout[3]), .stall_count(stall_count[3]), .flush_count(flush_count[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_fl[i] = 0; m_waits[i] = 0; m_fault[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    // Expected controls as {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze}.
    task automatic check_cycle();
        bit wn;
        logic [4:0] e, got;
        bit st_ev;
        wn = mem_req && !mem_ready;
        for (int i = 0; i < N; i++) begin
            st_ev = 1'b0;
            if (!rst)                e = 5'b00000;
            else if (m_fault[i])     e = 5'b11001;
            else if (wn)           begin e = 5'b11001; st_ev = 1'b1; end
            else if (m_fl[i] > 0)    e = 5'b00100;
            else if (hazard_detected) begin e = 5'b11010; st_ev = 1'b1; end
            else if (branch_taken)   e = 5'b00100;
            else                     e = 5'b00000;
            got = {pc_freeze[i], if_id_freeze[i], if_id_flush[i], id_exe_bubble[i], back_freeze[i]};
            check_eq($sformatf("ctrl[%0d]", i), 32'(got), 32'(e));
            check_eq($sformatf("flush_vs_freeze[%0d]", i), 32'(if_id_flush[i] & if_id_freeze[i]), 32'd0);
            check_eq($sformatf("mem_timeout[%0d]", i), 32'(mem_timeout[i]), 32'(m_fault[i]));
            check_eq($sformatf("stall_count[%0d]", i), stall_count[i], STATS ? sat32(m_sc[i]) : 32'd0);
            check_eq($sformatf("flush_count[%0d]", i), flush_count[i], STATS ? sat32(m_fc[i]) : 32'd0);
            if (rst) begin
                if (st_ev) m_sc[i]++;
                if (e[2])  m_fc[i]++;
                if (!m_fault[i]) begin
                    if (wn) begin
                        m_waits[i]++;
                        if (m_waits[i] >= wl_p[i]) m_fault[i] = 1'b1;
                    end else begin
                        m_waits[i] = 0;
                        if (m_fl[i] > 0)            m_fl[i]--;
                        else if (hazard_detected)   m_fl[i] = m_fl[i];
                        else if (branch_taken)      m_fl[i] = fc_p[i] - 1;
                    end
                end
            end
        end
        cycle++;
    endtask

    task automatic cycle_in(input bit h, input bit b, input bit req, input bit rdy);
        @(negedge clk);
        hazard_detected = h; branch_taken = b; mem_req = req; mem_ready = rdy;
        #1;
        check_cycle();
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must clear before any clock edge.
    task automatic reset_mid();
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rst_ctrl[%0d]", i),
                     32'({pc_freeze[i], if_id_freeze[i], if_id_flush[i], id_exe_bubble[i], back_freeze[i]}), 32'd0);
            check_eq($sformatf("rst_timeout[%0d]", i), 32'(mem_timeout[i]), 32'd0);
            check_eq($sformatf("rst_stall_count[%0d]", i), stall_count[i], 32'd0);
        end
        model_reset();
        hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        cycle_in(0, 0, 0, 0);
        cycle_in(1, 1, 1, 0);
        hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset checked, cycle %0d", cycle);

        cycle_in(1, 0, 0, 0); cycle_in(1, 0, 0, 0); cycle_in(0, 0, 0, 0);
        $display("[TB] hazard pulse done, cycle %0d", cycle);

        cycle_in(0, 1, 0, 0); cycle_in(0, 1, 0, 0); cycle_in(0, 0, 0, 0); cycle_in(0, 0, 0, 0);
        $display("[TB] branch flush sequence done, cycle %0d", cycle);

        cycle_in(1, 1, 0, 0); cycle_in(0, 0, 0, 0);
        $display("[TB] branch plus hazard done, cycle %0d", cycle);

        cycle_in(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle_in(0, 0, 1, 0);
        cycle_in(0, 0, 1, 1); cycle_in(0, 0, 0, 0); cycle_in(0, 0, 0, 0);
        $display("[TB] wait inside flush done, cycle %0d", cycle);
        reset_mid();

        for (int k = 0; k < 7; k++) cycle_in(0, 0, 1, 0);
        cycle_in(1, 1, 1, 1);
        $display("[TB] watchdog hold done, cycle %0d", cycle);
        reset_mid();

        cycle_in(0, 0, 1, 0); cycle_in(0, 0, 1, 0); cycle_in(0, 0, 1, 0); cycle_in(0, 0, 1, 1);
        cycle_in(1, 0, 0, 0);
        $display("[TB] ready at limit done, cycle %0d", cycle);
        reset_mid();

        for (int k = 0; k < 3000; k++) begin
            cycle_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) == 0) reset_mid();
        end
        $display("[TB] random phase done, cycle %0d", cycle);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
